// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : Bimodal branch predictor built on a table of 2-bit saturating
//               counters, plus execute-stage branch resolution, mispredict
//               redirect generation and saturating statistics counters.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   fetch_valid/_pc     lookup request; answered one cycle later on
//                       pred_valid / pred_taken
//   ex_valid, ex_branch execute-stage conditional branch qualifier
//   ex_branch_type      000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
//                       (010/011 are ignored)
//   ex_zero/_lt/_ltu    ALU compare flags
//   ex_pred_taken       prediction that travelled with the branch
//   ex_pc, ex_target    branch PC and taken target
//   pcMux               registered resolved-taken flag
//   mispredict          one-cycle redirect pulse
//   redirect_pc         correct next PC, held between resolves
//   branch_cnt          number of resolved legal branches (saturating)
//   mispred_cnt         number of mispredictions (saturating)
//
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    input  logic [XLEN-1:0]  fetch_pc,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [2:0]       ex_branch_type,
    input  logic             ex_zero,
    input  logic             ex_lt,
    input  logic             ex_ltu,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic             pcMux,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int         IDX_W      = $clog2(BHT_ENTRIES);
    localparam logic [1:0] C_CNT_INIT = 2'b01;   // weakly not-taken
    localparam logic [1:0] C_CNT_MAX  = 2'b11;
    localparam logic [1:0] C_CNT_MIN  = 2'b00;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic             pcmux_q, pcmux_d;
    logic             mispredict_q, mispredict_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // ------------------------------------------------------------------------
    // Resolution
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0] w_fetch_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_type_legal;
    logic             w_resolve;
    logic             w_taken;
    logic             w_mispredict;
    logic             w_unused_bits;

    assign w_fetch_idx  = fetch_pc[IDX_W+1:2];
    assign w_ex_idx     = ex_pc[IDX_W+1:2];
    // Types 010 and 011 are reserved encodings and never resolve.
    assign w_type_legal = (ex_branch_type[2:1] != 2'b01);
    assign w_resolve    = ex_valid & ex_branch & w_type_legal;
    assign w_mispredict = w_resolve & (w_taken != ex_pred_taken);

    // Only the index field of fetch_pc participates in the lookup.
    assign w_unused_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};

    always_comb begin
        w_taken = 1'b0;
        case (ex_branch_type)
            3'b000:  w_taken =  ex_zero;
            3'b001:  w_taken = ~ex_zero;
            3'b100:  w_taken =  ex_lt;
            3'b101:  w_taken = ~ex_lt;
            3'b110:  w_taken =  ex_ltu;
            3'b111:  w_taken = ~ex_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // Lookup reads the registered table, so a same-cycle update to the
        // same entry is seen by the following lookup, not this one.
        pred_valid_d = fetch_valid;
        pred_taken_d = fetch_valid & bht_q[w_fetch_idx][1];

        pcmux_d       = w_resolve & w_taken;
        mispredict_d  = w_mispredict;
        redirect_pc_d = redirect_pc_q;
        if (w_resolve) begin
            redirect_pc_d = w_taken ? ex_target : (ex_pc + XLEN'(4));
        end

        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (w_resolve && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (w_mispredict && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end

        for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_d[i] = bht_q[i];
        end
        if (w_resolve) begin
            if (w_taken) begin
                if (bht_q[w_ex_idx] != C_CNT_MAX) begin
                    bht_d[w_ex_idx] = bht_q[w_ex_idx] + 2'd1;
                end
            end else begin
                if (bht_q[w_ex_idx] != C_CNT_MIN) begin
                    bht_d[w_ex_idx] = bht_q[w_ex_idx] - 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= C_CNT_INIT;
            end
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pcmux_q       <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= bht_d[i];
            end
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pcmux_q       <= pcmux_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pcMux       = pcmux_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_pc_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Self-checking bench for branch_predict_unit. Directed vector
//               table, hand sequences for counter saturation and mid-run
//               reset, and randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 4;           // small so saturation is reachable
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             fetch_valid;
    logic [XLEN-1:0]  fetch_pc;
    logic             ex_valid;
    logic             ex_branch;
    logic [2:0]       ex_branch_type;
    logic             ex_zero;
    logic             ex_lt;
    logic             ex_ltu;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_target;
    logic             pred_valid;
    logic             pred_taken;
    logic             pcMux;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    branch_predict_unit #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (ENTRIES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_branch_type (ex_branch_type),
        .ex_zero        (ex_zero),
        .ex_lt          (ex_lt),
        .ex_ltu         (ex_ltu),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pcMux          (pcMux),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: counter strength 0..3 per entry, plain integers.
    int              m_bht [ENTRIES];
    int              m_bcnt;
    int              m_mcnt;
    logic [XLEN-1:0] m_rd;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input logic pv, input logic pt, input logic pcm,
                             input logic mp, input logic [XLEN-1:0] rd,
                             input int bc, input int mc, input string tag);
        check({tag, ".pred_valid"},  longint'(pred_valid),  longint'(pv));
        check({tag, ".pred_taken"},  longint'(pred_taken),  longint'(pt));
        check({tag, ".pcMux"},       longint'(pcMux),       longint'(pcm));
        check({tag, ".mispredict"},  longint'(mispredict),  longint'(mp));
        check({tag, ".redirect_pc"}, longint'(redirect_pc), longint'(rd));
        check({tag, ".branch_cnt"},  longint'(branch_cnt),  longint'(bc));
        check({tag, ".mispred_cnt"}, longint'(mispred_cnt), longint'(mc));
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
        m_bcnt = 0;
        m_mcnt = 0;
        m_rd   = '0;
    endtask

    // One clock of traffic. ctl = {fetch_valid, ex_valid, ex_branch,
    // ex_pred_taken}; cmp = {ex_zero, ex_lt, ex_ltu}.
    task automatic run_cycle(input logic [3:0] ctl, input logic [XLEN-1:0] fpc,
                             input logic [2:0] ty, input logic [2:0] cmp,
                             input logic [XLEN-1:0] epc, input logic [XLEN-1:0] tgt,
                             input string tag);
        int   fidx, eidx;
        bit   legal, taken;
        logic e_pv, e_pt, e_pcm, e_mp;

        fidx  = int'((fpc / 4) % ENTRIES);
        eidx  = int'((epc / 4) % ENTRIES);
        e_pv  = ctl[3];
        e_pt  = ctl[3] && (m_bht[fidx] >= 2);
        legal = ctl[2] && ctl[1] && (ty inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7});
        case (ty)
            3'd0:    taken =  cmp[2];
            3'd1:    taken = !cmp[2];
            3'd4:    taken =  cmp[1];
            3'd5:    taken = !cmp[1];
            3'd6:    taken =  cmp[0];
            3'd7:    taken = !cmp[0];
            default: taken = 1'b0;
        endcase
        e_pcm = legal && taken;
        e_mp  = legal && (taken != ctl[0]);
        if (legal) begin
            m_rd = taken ? tgt : epc + 32'd4;
            m_bht[eidx] = taken ? ((m_bht[eidx] < 3) ? m_bht[eidx] + 1 : 3)
                                : ((m_bht[eidx] > 0) ? m_bht[eidx] - 1 : 0);
            if (m_bcnt < CNT_MAX) m_bcnt++;
            if (e_mp && m_mcnt < CNT_MAX) m_mcnt++;
        end

        fetch_valid    = ctl[3];
        fetch_pc       = fpc;
        ex_valid       = ctl[2];
        ex_branch      = ctl[1];
        ex_pred_taken  = ctl[0];
        ex_branch_type = ty;
        ex_zero        = cmp[2];
        ex_lt          = cmp[1];
        ex_ltu         = cmp[0];
        ex_pc          = epc;
        ex_target      = tgt;
        @(posedge clk);
        #1;
        check_all(e_pv, e_pt, e_pcm, e_mp, m_rd, m_bcnt, m_mcnt, tag);
    endtask

    task automatic idle_inputs();
        fetch_valid = 0; fetch_pc = '0; ex_valid = 0; ex_branch = 0;
        ex_branch_type = '0; ex_zero = 0; ex_lt = 0; ex_ltu = 0;
        ex_pred_taken = 0; ex_pc = '0; ex_target = '0;
    endtask

    // Reset asserted between clock edges: outputs must clear without a clock.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_all(1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 0, tag);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]      ctl;
        logic [XLEN-1:0] fpc;
        logic [2:0]      ty;
        logic [2:0]      cmp;
        logic [XLEN-1:0] epc;
        logic [XLEN-1:0] tgt;
        logic [3:0]      eo;   // {pred_valid, pred_taken, pcMux, mispredict}
        logic [XLEN-1:0] erd;
        logic [3:0]      ebc;
        logic [3:0]      emc;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{4'b1000, 32'h40, 3'd0, 3'b000, 32'h0,   32'h0,   4'b1000, 32'h0,   4'd0, 4'd0};
        tbl[1] = '{4'b0110, 32'h0,  3'd0, 3'b100, 32'h40,  32'h80,  4'b0011, 32'h80,  4'd1, 4'd1};
        tbl[2] = '{4'b1000, 32'h40, 3'd0, 3'b000, 32'h0,   32'h0,   4'b1100, 32'h80,  4'd1, 4'd1};
        tbl[3] = '{4'b0111, 32'h0,  3'd7, 3'b001, 32'h100, 32'h200, 4'b0001, 32'h104, 4'd2, 4'd2};
        tbl[4] = '{4'b1110, 32'h40, 3'd2, 3'b100, 32'h40,  32'h80,  4'b1000, 32'h104, 4'd2, 4'd2};
        tbl[5] = '{4'b1111, 32'h44, 3'd1, 3'b000, 32'h44,  32'h300, 4'b1010, 32'h300, 4'd3, 4'd2};
        tbl[6] = '{4'b1111, 32'h44, 3'd4, 3'b010, 32'h48,  32'h400, 4'b1110, 32'h400, 4'd4, 4'd2};
        tbl[7] = '{4'b1110, 32'h48, 3'd6, 3'b000, 32'h48,  32'h500, 4'b1100, 32'h4c,  4'd5, 4'd2};
        tbl[8] = '{4'b1111, 32'h48, 3'd5, 3'b010, 32'h48,  32'h600, 4'b1001, 32'h4c,  4'd6, 4'd3};
        tbl[9] = '{4'b1010, 32'h48, 3'd0, 3'b100, 32'h48,  32'h0,   4'b1000, 32'h4c,  4'd6, 4'd3};

        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        do_reset("reset0");
        run_cycle(4'b0000, '0, 3'd0, 3'b000, '0, '0, "post_reset");

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_cycle(tbl[i].ctl, tbl[i].fpc, tbl[i].ty, tbl[i].cmp,
                      tbl[i].epc, tbl[i].tgt, $sformatf("vec%0d", i));
            check($sformatf("tbl%0d.flags", i),
                  longint'({pred_valid, pred_taken, pcMux, mispredict}), longint'(tbl[i].eo));
            check($sformatf("tbl%0d.redirect", i), longint'(redirect_pc), longint'(tbl[i].erd));
            check($sformatf("tbl%0d.bcnt", i), longint'(branch_cnt), longint'(tbl[i].ebc));
            check($sformatf("tbl%0d.mcnt", i), longint'(mispred_cnt), longint'(tbl[i].emc));
        end

        // Saturation on entry 3 with same-cycle lookup of the updated entry.
        for (int i = 0; i < 5; i++)
            run_cycle(4'b1111, 32'h0C, 3'd0, 3'b100, 32'h0C, 32'h900, "sat_up");
        run_cycle(4'b1000, 32'h0C, 3'd0, 3'b000, '0, '0, "sat_up_fetch");
        check("sat_up_pred", longint'(pred_taken), 64'd1);
        for (int i = 0; i < 5; i++)
            run_cycle(4'b1110, 32'h0C, 3'd0, 3'b000, 32'h0C, 32'h900, "sat_dn");
        run_cycle(4'b1000, 32'h0C, 3'd0, 3'b000, '0, '0, "sat_dn_fetch");
        check("sat_dn_pred", longint'(pred_taken), 64'd0);
        // From 00 one taken step must still predict not-taken.
        run_cycle(4'b0110, '0, 3'd0, 3'b100, 32'h0C, 32'h900, "sat_dn_step");
        run_cycle(4'b1000, 32'h0C, 3'd0, 3'b000, '0, '0, "sat_dn_step_fetch");
        check("sat_dn_step_pred", longint'(pred_taken), 64'd0);

        // Randomized traffic with aliasing PCs and the +4 wrap case.
        for (int i = 0; i < 400; i++) begin
            logic [3:0]      ctl;
            logic [XLEN-1:0] epc;
            ctl = 4'($urandom);
            if ($urandom_range(0, 3) != 0) ctl[2:1] = 2'b11;
            epc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
                                              : {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            run_cycle(ctl, {24'd0, 6'($urandom_range(0, 63)), 2'b00},
                      3'($urandom), 3'($urandom), epc, $urandom, "rand");
        end
        check("bcnt_saturated", longint'(branch_cnt), longint'(CNT_MAX));
        run_cycle(4'b0110, '0, 3'd1, 3'b000, 32'h20, 32'h40, "bcnt_sat_again");
        check("bcnt_stays_max", longint'(branch_cnt), longint'(CNT_MAX));

        // Mid-sequence reset with a resolve presented on the inputs.
        fetch_valid = 1; fetch_pc = 32'h40; ex_valid = 1; ex_branch = 1;
        ex_branch_type = 3'd0; ex_zero = 1; ex_pred_taken = 0;
        ex_pc = 32'h40; ex_target = 32'h80;
        do_reset("reset_mid");
        run_cycle(4'b0000, '0, 3'd0, 3'b000, '0, '0, "post_reset_mid");
        for (int i = 0; i < ENTRIES; i++)
            run_cycle(4'b1000, 32'(i * 4), 3'd0, 3'b000, '0, '0, "reinit_scan");
        // 01 -> 10 with a single taken resolve proves the reset value.
        run_cycle(4'b0110, '0, 3'd0, 3'b100, 32'h40, 32'h80, "reinit_step");
        run_cycle(4'b1000, 32'h40, 3'd0, 3'b000, '0, '0, "reinit_fetch");
        check("reinit_pred", longint'(pred_taken), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
